oaum_operand_normalizer: RTL and testbench

//  Upstream operand stage for the OAUM approximate multiplier mantissa datapath.
//  - Takes two unsigned integer operands and finds each operand's leading one (LOD).
//  - Left-normalises each operand so its leading one sits at bit BASELINE.
//  - Emits the fraction bits below the leading one as Mantissa_X / Mantissa_Y.
//  - Emits each operand's leading-zero count as lod_a_en / lod_b_en; the

---
 rtl/oaum_operand_normalizer.sv | 132 +++++++++++++
 tb/tb_oaum_operand_normalizer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oaum_operand_normalizer.sv
// Operand normaliser for the OAUM approximate multiplier mantissa datapath.
// It has two registered stages with valid/ready handshakes on both sides:
//   S1 captures both operands, their leading-zero counts and the zero flag.
//   S2 captures the left-normalised fractions with the hidden one dropped.
module oaum_operand_normalizer #(
  parameter int unsigned BASELINE       = 15,
  parameter int unsigned MANTISSA_WIDTH = 15,
  parameter int unsigned log_n          = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BASELINE:0]         op_a,
  input  logic [BASELINE:0]         op_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MANTISSA_WIDTH-1:0] Mantissa_X,
  output logic [MANTISSA_WIDTH-1:0] Mantissa_Y,
  output logic [log_n:0]            lod_a_en,
  output logic [log_n:0]            lod_b_en,
  output logic                      zero
);

  localparam int unsigned OpW = BASELINE + 1;
  localparam int unsigned LzW = log_n + 1;

  // Handshake
  logic adv1, adv2, accept;

  // Stage 1 state
  logic           s1_valid_q;
  logic [OpW-1:0] s1_a_q, s1_b_q;
  logic [LzW-1:0] s1_lzc_a_q, s1_lzc_b_q;
  logic           s1_zero_q;

  // Stage 2 state
  logic                      s2_valid_q;
  logic [MANTISSA_WIDTH-1:0] s2_mant_x_q, s2_mant_y_q;
  logic [LzW-1:0]            s2_lzc_a_q, s2_lzc_b_q;
  logic                      s2_zero_q;

  // Combinational stage results
  logic [LzW-1:0]            lzc_a, lzc_b;
  logic                      in_zero;
  logic [OpW-1:0]            norm_a, norm_b;
  logic [MANTISSA_WIDTH-1:0] mant_x, mant_y;

  // Pipeline advance: S2 frees when empty or draining, S1 frees when S2 can take it.
  always_comb begin
    adv2     = !s2_valid_q || out_ready;
    adv1     = !s1_valid_q || adv2;
    in_ready = adv1;
    accept   = in_valid && adv1;
  end

  // Leading-one detection: the highest set bit wins, so scan upward and let later hits override.
  always_comb begin
    lzc_a = LzW'(BASELINE);
    lzc_b = LzW'(BASELINE);
    for (int i = 0; i <= int'(BASELINE); i++) begin
      if (op_a[i]) lzc_a = LzW'(int'(BASELINE) - i);
      if (op_b[i]) lzc_b = LzW'(int'(BASELINE) - i);
    end
    in_zero = (op_a == '0) || (op_b == '0);
  end

  // Stage 1 register: the data registers load only on an actual transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_lzc_a_q <= '0;
      s1_lzc_b_q <= '0;
      s1_zero_q  <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q     <= op_a;
        s1_b_q     <= op_b;
        s1_lzc_a_q <= lzc_a;
        s1_lzc_b_q <= lzc_b;
        s1_zero_q  <= in_zero;
      end
    end
  end

  // Barrel normalisation and fraction slice. The hidden one at BASELINE is dropped.
  always_comb begin
    norm_a = s1_a_q << s1_lzc_a_q;
    norm_b = s1_b_q << s1_lzc_b_q;
    mant_x = norm_a[BASELINE-1 -: MANTISSA_WIDTH];
    mant_y = norm_b[BASELINE-1 -: MANTISSA_WIDTH];
    if (s1_zero_q) begin
      mant_x = '0;
      mant_y = '0;
    end
  end

  // Stage 2 register: it holds while stalled, which keeps the outputs stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_mant_x_q <= '0;
      s2_mant_y_q <= '0;
      s2_lzc_a_q  <= '0;
      s2_lzc_b_q  <= '0;
      s2_zero_q   <= 1'b0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_mant_x_q <= mant_x;
        s2_mant_y_q <= mant_y;
        s2_lzc_a_q  <= s1_lzc_a_q;
        s2_lzc_b_q  <= s1_lzc_b_q;
        s2_zero_q   <= s1_zero_q;
      end
    end
  end

  // Outputs come directly from the S2 registers.
  always_comb begin
    out_valid  = s2_valid_q;
    Mantissa_X = s2_mant_x_q;
    Mantissa_Y = s2_mant_y_q;
    lod_a_en   = s2_lzc_a_q;
    lod_b_en   = s2_lzc_b_q;
    zero       = s2_zero_q;
  end

endmodule

// File: tb/tb_oaum_operand_normalizer.sv
// Scoreboard bench for oaum_operand_normalizer: a 15-bit-fraction instance and an
// 8-bit-fraction instance share one input stream.
module tb_oaum_operand_normalizer;

  typedef struct packed {
    logic [14:0] mx;
    logic [14:0] my;
    logic [7:0]  mx8;
    logic [7:0]  my8;
    logic [4:0]  la;
    logic [4:0]  lb;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;

  logic        in_ready, out_valid, zero;
  logic [14:0] mant_x, mant_y;
  logic [4:0]  lod_a, lod_b;

  logic        in_ready8, out_valid8, zero8;
  logic [7:0]  mant_x8, mant_y8;
  logic [4:0]  lod_a8, lod_b8;

  int  nvec = 0;
  int  nfail = 0;
  bit  rand_ready = 1'b0;
  exp_t q[$];
  exp_t q8[$];

  oaum_operand_normalizer #(.BASELINE(15), .MANTISSA_WIDTH(15), .log_n(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .Mantissa_X(mant_x), .Mantissa_Y(mant_y), .lod_a_en(lod_a), .lod_b_en(lod_b),
    .zero(zero)
  );

  oaum_operand_normalizer #(.BASELINE(15), .MANTISSA_WIDTH(8), .log_n(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid8), .out_ready(out_ready),
    .Mantissa_X(mant_x8), .Mantissa_Y(mant_y8), .lod_a_en(lod_a8), .lod_b_en(lod_b8),
    .zero(zero8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Leading zeros counted as 15 minus the position of the highest power of two in v.
  function automatic int ref_lzc(input logic [15:0] v);
    int msb = -1;
    int t = int'(v);
    while (t > 0) begin
      msb++;
      t = t / 2;
    end
    return (v == 16'd0) ? 15 : 15 - msb;
  endfunction

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int la, lb, na, nb;
    la = ref_lzc(a);
    lb = ref_lzc(b);
    na = (int'(a) * (1 << la)) % 65536;
    nb = (int'(b) * (1 << lb)) % 65536;
    e.z   = (a == 16'd0) || (b == 16'd0);
    e.la  = 5'(la);
    e.lb  = 5'(lb);
    e.mx  = e.z ? 15'd0 : 15'(na % 32768);
    e.my  = e.z ? 15'd0 : 15'(nb % 32768);
    e.mx8 = e.z ? 8'd0 : 8'((na / 128) % 256);
    e.my8 = e.z ? 8'd0 : 8'((nb / 128) % 256);
    return e;
  endfunction

  function automatic exp_t mk(input logic [14:0] mx, input logic [14:0] my,
                              input logic [7:0] mx8, input logic [7:0] my8,
                              input logic [4:0] la, input logic [4:0] lb, input logic z);
    exp_t e;
    e.mx = mx; e.my = my; e.mx8 = mx8; e.my8 = my8; e.la = la; e.lb = lb; e.z = z;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input exp_t e);
    bit exp_rdy;
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      exp_rdy = !(q.size() >= 2 && !out_ready);
      check("in_ready", {in_ready, in_ready8}, {exp_rdy, exp_rdy});
      if (in_ready) begin
        q.push_back(e);
        q8.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("issue_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic issue_model(input logic [15:0] a, input logic [15:0] b);
    issue(a, b, model(a, b));
  endtask

  // Monitor for the wide instance: compares the front every valid cycle and pops on transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        check("stale_out", {63'd0, out_valid}, 64'd0);
      end else begin
        check("out15", {mant_x, mant_y, lod_a, lod_b, zero},
              {q[0].mx, q[0].my, q[0].la, q[0].lb, q[0].z});
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // Monitor for the narrow instance.
  always @(negedge clk) begin
    if (rst_n && out_valid8) begin
      if (q8.size() == 0) begin
        check("stale_out8", {63'd0, out_valid8}, 64'd0);
      end else begin
        check("out8", {mant_x8, mant_y8, lod_a8, lod_b8, zero8},
              {q8[0].mx8, q8[0].my8, q8[0].la, q8[0].lb, q8[0].z});
        if (out_ready) void'(q8.pop_front());
      end
    end
  end

  // Random backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic drain(input string name);
    for (int t = 0; t < 100 && (q.size() > 0 || q8.size() > 0); t++) @(posedge clk);
    check(name, 64'(q.size() + q8.size()), 64'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    #1;
    check("reset_state", {in_ready, out_valid, mant_x, mant_y, lod_a, lod_b, zero},
          {1'b1, 1'b0, 41'd0});
    check("reset_state8", {in_ready8, out_valid8, mant_x8, mant_y8, lod_a8, lod_b8, zero8},
          {1'b1, 1'b0, 27'd0});
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Directed points, including the truncation case for the 8-bit instance.
    issue(16'h8000, 16'h0001, mk(15'h0000, 15'h0000, 8'h00, 8'h00, 5'd0, 5'd15, 1'b0));
    issue(16'h00C0, 16'h1234, mk(15'h4000, 15'h11A0, 8'h80, 8'h23, 5'd8, 5'd3, 1'b0));
    issue(16'h0000, 16'h5555, mk(15'h0000, 15'h0000, 8'h00, 8'h00, 5'd15, 5'd1, 1'b1));
    issue(16'hFFFF, 16'h0001, mk(15'h7FFF, 15'h0000, 8'hFF, 8'h00, 5'd0, 5'd15, 1'b0));
    drain("drain_directed");

    // Four back-to-back pairs into a stalled pipe.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    fork
      begin
        issue_model(16'h0001, 16'h0002);
        issue_model(16'h0300, 16'hFFFF);
        issue_model(16'h4001, 16'h0000);
        issue_model(16'h00F0, 16'h7FFF);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    // Asynchronous reset with two pairs held in the pipe.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue_model(16'h1111, 16'h2222);
    issue_model(16'h3333, 16'h4444);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", {out_valid, in_ready, mant_x, mant_y, lod_a, lod_b, zero},
          {1'b0, 1'b1, 41'd0});
    check("async_reset8", {out_valid8, in_ready8}, {1'b0, 1'b1});
    q.delete();
    q8.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("no_stale", {in_ready, out_valid, out_valid8}, {1'b1, 1'b0, 1'b0});
    end
    @(posedge clk);
    #1;

    // Random operands with a random leading-one position and random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      ra = 16'($urandom) & 16'((32'd1 << $urandom_range(0, 16)) - 1);
      rb = 16'($urandom) & 16'((32'd1 << $urandom_range(0, 16)) - 1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      issue_model(ra, rb);
    end
    @(posedge clk);
    #1;
    rand_ready = 1'b0;
    #1;
    out_ready = 1'b1;
    drain("drain_random");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
